// File: rtl/dlx_dmem_pkg.sv
// Shared types and constants for the DLX data-memory responder.
package dlx_dmem_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int CNT_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dlx_dmem_ram.sv
// Single-port synchronous RAM: write on enable, registered read held between reads.
module dlx_dmem_ram
  import dlx_dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [0:(2**ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Array storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= {DATA_WIDTH{1'b0}};
    end else if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dlx_dmem_responder.sv
// MEM-stage data-memory responder with programmable wait states.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dlx_dmem_responder
  import dlx_dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           d_address,
  input  logic [DATA_WIDTH-1:0] d_data_write,
  input  logic                  d_write_enable,
  input  logic                  d_read_enable,
  output logic [DATA_WIDTH-1:0] d_data_read,
  output logic                  d_data_valid,
  output logic                  busy,
  output logic                  d_misaligned
);

  localparam logic [CNT_WIDTH-1:0] WAIT_LOAD = CNT_WIDTH'(WAIT_STATES);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic                  mis_req_q, mis_req_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  mis_q, mis_d;
  logic                  rd_zero_q, rd_zero_d;

  logic                  req_mis;
  logic                  complete;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_write;
  logic                  sel_mis;
  logic                  ram_we;
  logic                  ram_re;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  unused_addr_bits;

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_mis = (d_address[1:0] != 2'b00);
`else
  assign req_mis = 1'b0;
`endif

  assign unused_addr_bits = ^{d_address[31:ADDR_WIDTH+2], d_address[1:0]};

  // The RAM is accessed on the edge entering RESP; with zero wait states that
  // edge is the acceptance edge itself, so the live request is used there.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    mis_req_d = mis_req_q;
    rd_zero_d = rd_zero_q;
    complete  = 1'b0;

    if (state_q == IDLE) begin
      sel_addr  = d_address[ADDR_WIDTH+1:2];
      sel_wdata = d_data_write;
      sel_write = d_write_enable;
      sel_mis   = req_mis;
    end else begin
      sel_addr  = addr_q;
      sel_wdata = wdata_q;
      sel_write = write_q;
      sel_mis   = mis_req_q;
    end

    case (state_q)
      IDLE: begin
        if (d_write_enable || d_read_enable) begin
          addr_d    = d_address[ADDR_WIDTH+1:2];
          wdata_d   = d_data_write;
          write_d   = d_write_enable;
          mis_req_d = req_mis;
          cnt_d     = WAIT_LOAD;
          if (WAIT_STATES == 0) begin
            state_d  = RESP;
            complete = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(1)) begin
          state_d  = RESP;
          complete = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A misaligned read reports zero until the next completed read.
    if (complete && !sel_write) begin
      rd_zero_d = sel_mis;
    end else begin
      rd_zero_d = rd_zero_q;
    end

    ram_we  = complete && sel_write && !sel_mis && !reset;
    ram_re  = complete && !sel_write && !sel_mis;
    valid_d = (state_d == RESP);
    busy_d  = (state_d != IDLE);
    mis_d   = complete && sel_mis;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= {CNT_WIDTH{1'b0}};
      addr_q    <= {ADDR_WIDTH{1'b0}};
      wdata_q   <= {DATA_WIDTH{1'b0}};
      write_q   <= 1'b0;
      mis_req_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      mis_q     <= 1'b0;
      rd_zero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      mis_req_q <= mis_req_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      mis_q     <= mis_d;
      rd_zero_q <= rd_zero_d;
    end
  end

  dlx_dmem_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (ram_we),
    .re   (ram_re),
    .addr (sel_addr),
    .wdata(sel_wdata),
    .rdata(ram_rdata)
  );

  assign d_data_read  = rd_zero_q ? {DATA_WIDTH{1'b0}} : ram_rdata;
  assign d_data_valid = valid_q;
  assign busy         = busy_q;
  assign d_misaligned = mis_q;

endmodule

// File: tb/tb_dlx_dmem_responder.sv
// Bench for dlx_dmem_responder: directed table, WS=0 back-to-back, reset abort, random vs model.
module tb_dlx_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        we0, re0, we1, re1;
  logic [31:0] a0, a1, wd0, wd1;
  logic [31:0] rd0, rd1;
  logic        v0, v1, b0, b1, m0, m1;

  dlx_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .reset(rst), .d_address(a0), .d_data_write(wd0),
    .d_write_enable(we0), .d_read_enable(re0), .d_data_read(rd0),
    .d_data_valid(v0), .busy(b0), .d_misaligned(m0)
  );

  dlx_dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(rst), .d_address(a1), .d_data_write(wd1),
    .d_write_enable(we1), .d_read_enable(re1), .d_data_read(rd1),
    .d_data_valid(v1), .busy(b1), .d_misaligned(m1)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: word-indexed memory per instance plus last read result.
  logic [31:0] mdl_mem   [2][1024];
  bit          mdl_known [2][1024];
  logic [31:0] mdl_rd    [2];
  bit          mdl_rd_ok [2];

  typedef struct {
    bit          w;
    bit          r;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_mis;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int k, input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    if (k == 0) begin
      we0 = w; re0 = r; a0 = a; wd0 = d;
    end else begin
      we1 = w; re1 = r; a1 = a; wd1 = d;
    end
  endtask

  task automatic sample(input int k, output logic [31:0] rd, output bit v, output bit b, output bit m);
    if (k == 0) begin
      rd = rd0; v = v0; b = b0; m = m0;
    end else begin
      rd = rd1; v = v1; b = b1; m = m1;
    end
  endtask

  task automatic model_access(input int k, input bit w, input bit r, input logic [31:0] a,
                              input logic [31:0] d, output logic [31:0] exp_rd,
                              output bit exp_mis, output bit rd_ok);
    int word;
    word    = int'(a[11:2]);
    exp_mis = ALIGN && (a[1:0] != 2'b00);
    if (w) begin
      if (!exp_mis) begin
        mdl_mem[k][word]   = d;
        mdl_known[k][word] = 1'b1;
      end
    end else if (r) begin
      if (exp_mis) begin
        mdl_rd[k]    = 32'h0;
        mdl_rd_ok[k] = 1'b1;
      end else begin
        mdl_rd[k]    = mdl_mem[k][word];
        mdl_rd_ok[k] = mdl_known[k][word];
      end
    end
    exp_rd = mdl_rd[k];
    rd_ok  = mdl_rd_ok[k];
  endtask

  task automatic access(input int k, input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] d, input bit check_rd,
                        input logic [31:0] exp_rd, input bit exp_mis);
    int          ws;
    int          cyc;
    bit          got;
    bit          busy_ok;
    logic [31:0] rd;
    bit          v, b, m;
    ws      = (k == 0) ? 2 : 0;
    cyc     = 0;
    got     = 1'b0;
    busy_ok = 1'b1;
    rd      = 32'h0;
    m       = 1'b0;
    @(negedge clk);
    drive(k, w, r, a, d);
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      sample(k, rd, v, b, m);
      if (!b) busy_ok = 1'b0;
      if (v) got = 1'b1;
    end
    drive(k, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("latency", got ? 32'(cyc) : 32'd999, 32'(ws + 1));
    chk("busy_in_flight", {31'd0, busy_ok}, 32'd1);
    if (check_rd) chk("rdata", rd, exp_rd);
    chk("misaligned", {31'd0, m}, {31'd0, exp_mis});
    @(negedge clk);
    sample(k, rd, v, b, m);
    chk("pulse_end", {30'd0, v, b}, 32'd0);
  endtask

  task automatic do_access(input int k, input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] er;
    bit          em, ok;
    model_access(k, w, r, a, d, er, em, ok);
    access(k, w, r, a, d, ok, er, em);
  endtask

  initial begin
    logic [31:0] er;
    bit          em, ok;
    int          pulses;
    logic [31:0] rnd;
    logic [31:0] addr;
    logic [1:0]  lo;
    int          op;

    tbl[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 32'h1000_0004, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'h0000_0030, 32'h0BAD_F00D, 32'hA5A5_A5A5, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_0055, 32'hA5A5_A5A5, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'h0000_0008, 32'h0000_0000, 32'h0000_0055, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 32'h0000_0030, 32'h0000_0000, 32'h0BAD_F00D, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 32'h0000_0031, 32'h1111_1111, 32'h0BAD_F00D, ALIGN};
    tbl[9]  = '{1'b0, 1'b1, 32'h0000_0032, 32'h0000_0000,
                ALIGN ? 32'h0000_0000 : 32'h1111_1111, ALIGN};
    tbl[10] = '{1'b0, 1'b1, 32'h0000_0030, 32'h0000_0000,
                ALIGN ? 32'h0BAD_F00D : 32'h1111_1111, 1'b0};

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 1024; i++) mdl_known[k][i] = 1'b0;
      mdl_rd[k]    = 32'h0;
      mdl_rd_ok[k] = 1'b1;
    end

    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ws2", {rd0[31:3], v0, b0, m0}, 32'h0);
    chk("reset_ws2_rd", rd0, 32'h0);
    chk("reset_ws0", {29'd0, v1, b1, m1}, 32'h0);
    chk("reset_ws0_rd", rd1, 32'h0);

    // Directed table on the two-wait-state instance.
    for (int i = 0; i < 11; i++) begin
      model_access(0, tbl[i].w, tbl[i].r, tbl[i].addr, tbl[i].wdata, er, em, ok);
      access(0, tbl[i].w, tbl[i].r, tbl[i].addr, tbl[i].wdata, 1'b1, tbl[i].exp_rd, tbl[i].exp_mis);
    end

    // Zero-wait-state instance: write/read, then a held request completes every 2 cycles.
    do_access(1, 1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678);
    do_access(1, 1'b0, 1'b1, 32'h0000_0020, 32'h0);
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 32'h0000_0020, 32'h0);
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("b2b_valid", {31'd0, v1}, {31'd0, 1'(i % 2)});
      if (v1) begin
        pulses++;
        chk("b2b_rdata", rd1, 32'h1234_5678);
      end
    end
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("b2b_pulses", 32'(pulses), 32'd5);
    @(negedge clk);

    // Reset during WAIT aborts a write.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h0000_0030, 32'hFFFF_0000);
    @(negedge clk);
    chk("abort_busy_before", {31'd0, b0}, 32'd1);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdl_rd[0] = 32'h0;
    mdl_rd[1] = 32'h0;
    mdl_rd_ok[0] = 1'b1;
    mdl_rd_ok[1] = 1'b1;
    chk("abort_state", {30'd0, v0, b0}, 32'd0);
    chk("abort_rd_cleared", rd0, 32'h0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (v0) pulses++;
    end
    chk("abort_no_valid", 32'(pulses), 32'd0);
    model_access(0, 1'b0, 1'b1, 32'h0000_0030, 32'h0, er, em, ok);
    access(0, 1'b0, 1'b1, 32'h0000_0030, 32'h0, 1'b1, tbl[10].exp_rd, 1'b0);

    // Preload a small window so every random read has a known expectation.
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 16; w++) begin
        do_access(k, 1'b1, 1'b0, 32'(w * 4), $urandom);
      end
    end

    for (int n = 0; n < 160; n++) begin
      rnd  = $urandom;
      lo   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      addr = {rnd[31:12], 6'b0, 4'($urandom_range(0, 15)), lo};
      op   = $urandom_range(0, 3);
      do_access(n % 2, (op == 0) || (op == 2), (op != 0), addr, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dlx_dmem_responder.md
Name: dlx_dmem_responder

Overview:
- Data-memory responder for the DLX pipeline: the memory-side end of the MEM-stage data interface.
- Samples MEM-stage requests (d_address, d_data_write, d_write_enable, d_read_enable) and performs word reads/writes on an internal synchronous RAM after a configurable number of wait states.
- Signals completion with a one-cycle d_data_valid pulse; the MEM stage stalls on it.

Parameters:
- ADDR_WIDTH, 10: word-address bits; RAM depth = 2**ADDR_WIDTH 32-bit words.
- WAIT_STATES, 2: extra cycles between request acceptance and response (0..15).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- d_address  input  32  byte address; word index = d_address[ADDR_WIDTH+1:2].
- d_data_write  input  32  write data.
- d_write_enable  input  1  write request.
- d_read_enable  input  1  read (load) request.
- d_data_read  output  32  read data, valid when d_data_valid=1.
- d_data_valid  output  1  one-cycle completion pulse (reads and writes).
- busy  output  1  high while a request is in flight (WAIT or RESP).
- d_misaligned  output  1  alignment-error flag (see Optional Feature).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: d_data_read=0, d_data_valid=0, busy=0, d_misaligned=0, state=IDLE, wait counter=0. RAM contents are not cleared.
- Initiator rule: request signals are held stable from first assertion until the cycle d_data_valid=1, then dropped or changed.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if d_write_enable|d_read_enable, latch address, data and op; load counter=WAIT_STATES; go to WAIT if WAIT_STATES>0, else RESP.
  - WAIT: decrement counter; go to RESP when counter reaches 1.
  - RESP: d_data_valid=1 for exactly this cycle; go to IDLE.
- Timing:
  - Latency: request accepted at edge t gives d_data_valid high in cycle t+1+WAIT_STATES.
  - Throughput: one access per WAIT_STATES+2 cycles. A request still asserted in the cycle after RESP is accepted as a new request.
- Write: RAM updated at the RESP edge using latched address/data. d_data_read holds its previous value.
- Read: d_data_read registered from RAM at the RESP edge, then held unchanged until the next completed read.
- Simultaneous write and read enables: treated as a write only; read data not updated.
- Address wrap: bits above ADDR_WIDTH+1 ignored (aliasing). Bits [1:0] ignored unless the Optional Feature is enabled.
- Request inputs are ignored in WAIT and RESP; only the latched values are used.
- Reset mid-operation: aborts the access, no RAM write, no d_data_valid pulse, state returns to IDLE.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - A request with d_address[1:0]!=0 is accepted and completes with normal latency.
  - d_misaligned=1 in the RESP cycle alongside d_data_valid.
  - A misaligned write does not modify the RAM; a misaligned read returns 32'h0.
- Undefined: d_misaligned tied to 0; bits [1:0] ignored.

Decomposition:
- Package dlx_dmem_pkg holds:
  - state enum (IDLE, WAIT, RESP)
  - DATA_WIDTH=32 constant
  - wait-counter width constant (4)
- Natural sub-module: dlx_dmem_ram, single-port synchronous RAM (write enable, registered read), parameterised by ADDR_WIDTH.

Test Plan:
- Reset, then write 0xDEADBEEF to address 0x10 with WAIT_STATES=2 -> d_data_valid pulses exactly 3 cycles after acceptance, busy high for cycles 1-3; read of 0x10 then returns d_data_read=0xDEADBEEF.
- WAIT_STATES=0: read of 0x20 after writing 0x12345678 -> valid in the cycle after acceptance, data 0x12345678; back-to-back requests complete every 2 cycles.
- Aliasing with ADDR_WIDTH=10: write 0xA5A5A5A5 to 0x1000_0004, read 0x0000_0004 -> 0xA5A5A5A5.
- Simultaneous d_write_enable=d_read_enable=1, address 0x8, data 0x55 -> RAM[2]=0x55, d_data_read keeps its prior value, single valid pulse.
- Reset asserted in WAIT during a write of 0xFFFF0000 to 0x30 -> no valid pulse, state IDLE; subsequent read of 0x30 returns the old contents.
- With DMEM_ALIGN_CHECK_EN: write to 0x31 -> d_misaligned=1 with d_data_valid and RAM unchanged; read from 0x32 -> d_data_read=0, d_misaligned=1.
